// File: rtl/dec8b10b_defs.sv
// Shared definitions for the 10b/8b decoder: word-sync states, comma codes and
// sub-block disparity classes with the helpers that apply the running-disparity rule.
package dec8b10b_defs;

  typedef enum logic [1:0] {
    SIN_SINC = 2'd0,
    ADQ      = 2'd1,
    SINC     = 2'd2
  } sync_state_t;

  localparam logic [9:0] K28_5_NEG  = 10'b0011111010;
  localparam logic [9:0] K28_5_POS  = 10'b1100000101;
  localparam logic [5:0] K28_6B_NEG = 6'b001111;
  localparam logic [5:0] K28_6B_POS = 6'b110000;

  // BALP/BALN are balanced sub-blocks (111000, 1100 / 000111, 0011) that are
  // still only legal at one running disparity.
  typedef enum logic [2:0] {
    SD_BAL  = 3'd0,
    SD_POS2 = 3'd1,
    SD_NEG2 = 3'd2,
    SD_BALP = 3'd3,
    SD_BALN = 3'd4
  } sub_disp_t;

  function automatic sub_disp_t disp_4b(input logic [3:0] c);
    sub_disp_t d;
    d = SD_BAL;
    case ($countones(c))
      3: d = SD_POS2;
      1: d = SD_NEG2;
      2: begin
        if (c == 4'b1100) d = SD_BALP;
        else if (c == 4'b0011) d = SD_BALN;
      end
      default: d = SD_BAL;
    endcase
    return d;
  endfunction

  function automatic logic disp_violation(input sub_disp_t d, input logic rd);
    return (rd && (d == SD_POS2 || d == SD_BALP)) ||
           (!rd && (d == SD_NEG2 || d == SD_BALN));
  endfunction

  // An unbalanced sub-block always leaves RD equal to its own sign, which also
  // covers the forced-RD case after a violation.
  function automatic logic rd_after(input sub_disp_t d, input logic rd);
    logic r;
    r = rd;
    if (d == SD_POS2) r = 1'b1;
    else if (d == SD_NEG2) r = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/dec_6b5b.sv
// Combinational 6b (abcdei) to 5b (EDCBA) lookup with validity, sub-block
// disparity class and K28 detection.
module dec_6b5b
  import dec8b10b_defs::*;
(
  input  logic [5:0] code,
  output logic [4:0] data,
  output logic       valid,
  output sub_disp_t  disp,
  output logic       k28
);

  always_comb begin
    data  = 5'd0;
    valid = 1'b1;
    case (code)
      6'b100111, 6'b011000: data = 5'd0;
      6'b011101, 6'b100010: data = 5'd1;
      6'b101101, 6'b010010: data = 5'd2;
      6'b110001:            data = 5'd3;
      6'b110101, 6'b001010: data = 5'd4;
      6'b101001:            data = 5'd5;
      6'b011001:            data = 5'd6;
      6'b111000, 6'b000111: data = 5'd7;
      6'b111001, 6'b000110: data = 5'd8;
      6'b100101:            data = 5'd9;
      6'b010101:            data = 5'd10;
      6'b110100:            data = 5'd11;
      6'b001101:            data = 5'd12;
      6'b101100:            data = 5'd13;
      6'b011100:            data = 5'd14;
      6'b010111, 6'b101000: data = 5'd15;
      6'b011011, 6'b100100: data = 5'd16;
      6'b100011:            data = 5'd17;
      6'b010011:            data = 5'd18;
      6'b110010:            data = 5'd19;
      6'b001011:            data = 5'd20;
      6'b101010:            data = 5'd21;
      6'b011010:            data = 5'd22;
      6'b111010, 6'b000101: data = 5'd23;
      6'b110011, 6'b001100: data = 5'd24;
      6'b100110:            data = 5'd25;
      6'b010110:            data = 5'd26;
      6'b110110, 6'b001001: data = 5'd27;
      6'b001110:            data = 5'd28;
      6'b101110, 6'b010001: data = 5'd29;
      6'b011110, 6'b100001: data = 5'd30;
      6'b101011, 6'b010100: data = 5'd31;
      K28_6B_NEG, K28_6B_POS: data = 5'd28;
      default:              valid = 1'b0;
    endcase
  end

  always_comb begin
    disp = SD_BAL;
    case ($countones(code))
      4: disp = SD_POS2;
      2: disp = SD_NEG2;
      3: begin
        if (code == 6'b111000) disp = SD_BALP;
        else if (code == 6'b000111) disp = SD_BALN;
      end
      default: disp = SD_BAL;
    endcase
  end

  assign k28 = (code == K28_6B_NEG) || (code == K28_6B_POS);

endmodule

// File: rtl/decoder_10b8b.sv
// 10b/8b decoder with running-disparity tracking and comma-based word sync.
// Optional saturating word-error counter enabled by `define DEC_CONT_ERR_EN.
module decoder_10b8b
  import dec8b10b_defs::*;
#(
  parameter int ERR_PERDIDA = 3,
  parameter int COMAS_SINC  = 3,
  parameter int ANCHO_CONT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic [9:0]            entradas,
  output logic [7:0]            salidas,
  output logic                  K,
  output logic                  valido,
  output logic                  err_codigo,
  output logic                  err_disp,
  output logic                  rd,
  output logic                  sincronizado,
  output logic [ANCHO_CONT-1:0] cont_err
);

  localparam int CW_C = $clog2(COMAS_SINC + 1);
  localparam int CW_E = $clog2(ERR_PERDIDA + 1);
  localparam logic [CW_C-1:0] COMAS_LIM = CW_C'(COMAS_SINC);
  localparam logic [CW_E-1:0] ERR_LIM   = CW_E'(ERR_PERDIDA);

  logic [5:0] six;
  logic [3:0] four_raw;
  logic [3:0] four_eff;
  logic [4:0] data5;
  logic       valid6;
  sub_disp_t  disp6;
  sub_disp_t  disp4;
  logic       k28;
  logic [2:0] hgf;
  logic       valid4;
  logic       a7;
  logic       a7_data;
  logic       k_ext;
  logic       a7_bad;
  logic       k_dec;
  logic       err_cod;
  logic       err_dsp;
  logic       word_err;
  logic       comma;
  logic       rd_mid;
  logic       rd_new;

  logic [7:0] salidas_reg;
  logic       k_reg;
  logic       valido_reg;
  logic       err_codigo_reg;
  logic       err_disp_reg;
  logic       rd_reg;

  sync_state_t     state_reg, state_next;
  logic [CW_C-1:0] comma_cnt_reg, comma_cnt_next;
  logic [CW_E-1:0] err_cnt_reg, err_cnt_next;

  assign six      = entradas[9:4];
  assign four_raw = entradas[3:0];

  dec_6b5b u_dec_6b5b (
    .code  (six),
    .data  (data5),
    .valid (valid6),
    .disp  (disp6),
    .k28   (k28)
  );

  // K28 in its RD+ form is the bitwise complement of the RD- form, so its
  // 4b part is complemented before the shared lookup.
  assign four_eff = (k28 && disp6 == SD_NEG2) ? ~four_raw : four_raw;

  always_comb begin
    hgf    = 3'd0;
    valid4 = 1'b1;
    a7     = 1'b0;
    case (four_eff)
      4'b1011, 4'b0100: hgf = 3'd0;
      4'b1001:          hgf = 3'd1;
      4'b0101:          hgf = 3'd2;
      4'b1100, 4'b0011: hgf = 3'd3;
      4'b1101, 4'b0010: hgf = 3'd4;
      4'b1010:          hgf = 3'd5;
      4'b0110:          hgf = 3'd6;
      4'b1110, 4'b0001: hgf = 3'd7;
      4'b0111, 4'b1000: begin
        hgf = 3'd7;
        a7  = 1'b1;
      end
      default:          valid4 = 1'b0;
    endcase
  end

  // The alternate x.7 form is legal only after the six data codes that need
  // it for run length, or after a 6b code that can start a K character.
  assign a7_data = data5 inside {5'd11, 5'd13, 5'd14, 5'd17, 5'd18, 5'd20};
  assign k_ext   = data5 inside {5'd23, 5'd27, 5'd29, 5'd30};
  assign a7_bad  = a7 && !(k28 || a7_data || k_ext);
  assign k_dec   = k28 || (a7 && k_ext);
  assign err_cod = !valid6 || !valid4 || a7_bad;

  assign disp4   = disp_4b(four_raw);
  assign rd_mid  = rd_after(disp6, rd_reg);
  assign rd_new  = rd_after(disp4, rd_mid);
  assign err_dsp = !err_cod &&
                   (disp_violation(disp6, rd_reg) || disp_violation(disp4, rd_mid));
  assign word_err = err_cod || err_dsp;

  // abcdeif = 0011111 / 1100000 only occurs in K28.1, K28.5 and K28.7.
  assign comma = !word_err &&
                 (entradas[9:3] == K28_5_NEG[9:3] || entradas[9:3] == K28_5_POS[9:3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      salidas_reg    <= 8'h00;
      k_reg          <= 1'b0;
      valido_reg     <= 1'b0;
      err_codigo_reg <= 1'b0;
      err_disp_reg   <= 1'b0;
      rd_reg         <= 1'b0;
    end else begin
      valido_reg <= enb;
      if (enb) begin
        err_codigo_reg <= err_cod;
        err_disp_reg   <= err_dsp;
        if (err_cod) begin
          salidas_reg <= 8'h00;
          k_reg       <= 1'b0;
        end else begin
          salidas_reg <= {hgf, data5};
          k_reg       <= k_dec;
          rd_reg      <= rd_new;
        end
      end else begin
        err_codigo_reg <= 1'b0;
        err_disp_reg   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SIN_SINC;
      comma_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      comma_cnt_reg <= comma_cnt_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    comma_cnt_next = comma_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    if (enb) begin
      case (state_reg)
        SIN_SINC: begin
          if (comma) begin
            comma_cnt_next = CW_C'(1);
            err_cnt_next   = '0;
            state_next     = (COMAS_LIM <= CW_C'(1)) ? SINC : ADQ;
          end
        end
        ADQ: begin
          if (word_err) begin
            state_next     = SIN_SINC;
            comma_cnt_next = '0;
          end else if (comma) begin
            comma_cnt_next = comma_cnt_reg + CW_C'(1);
            if (comma_cnt_next == COMAS_LIM) begin
              state_next   = SINC;
              err_cnt_next = '0;
            end
          end
        end
        SINC: begin
          if (word_err) begin
            err_cnt_next = err_cnt_reg + CW_E'(1);
            if (err_cnt_next == ERR_LIM) begin
              state_next     = SIN_SINC;
              err_cnt_next   = '0;
              comma_cnt_next = '0;
            end
          end else begin
            err_cnt_next = '0;
          end
        end
        default: begin
          state_next     = SIN_SINC;
          comma_cnt_next = '0;
          err_cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef DEC_CONT_ERR_EN
  logic [ANCHO_CONT-1:0] cont_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cont_reg <= '0;
    end else if (enb && word_err && cont_reg != {ANCHO_CONT{1'b1}}) begin
      cont_reg <= cont_reg + ANCHO_CONT'(1);
    end
  end

  assign cont_err = cont_reg;
`else
  assign cont_err = '0;
`endif

  assign salidas      = salidas_reg;
  assign K            = k_reg;
  assign valido       = valido_reg;
  assign err_codigo   = err_codigo_reg;
  assign err_disp     = err_disp_reg;
  assign rd           = rd_reg;
  assign sincronizado = (state_reg == SINC);

endmodule

// File: tb/tb_decoder_10b8b.sv
// Bench for decoder_10b8b: an 8b/10b encoder builds a code dictionary, disparity is
// modelled by bit counting, and directed plus random streams are compared each word.
module tb_decoder_10b8b;
  import dec8b10b_defs::*;

  localparam int ANCHO_CONT = 16;
  localparam int CONT_MAX   = (1 << ANCHO_CONT) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enb;
  logic [9:0]            entradas;
  logic [7:0]            salidas;
  logic                  K;
  logic                  valido;
  logic                  err_codigo;
  logic                  err_disp;
  logic                  rd;
  logic                  sincronizado;
  logic [ANCHO_CONT-1:0] cont_err;

  decoder_10b8b #(
    .ERR_PERDIDA (3),
    .COMAS_SINC  (3),
    .ANCHO_CONT  (ANCHO_CONT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .entradas     (entradas),
    .salidas      (salidas),
    .K            (K),
    .valido       (valido),
    .err_codigo   (err_codigo),
    .err_disp     (err_disp),
    .rd           (rd),
    .sincronizado (sincronizado),
    .cont_err     (cont_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int steps  = 0;

  // RD- column of the 5b/6b and 3b/4b encoding tables.
  logic [5:0] enc6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                            6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                            6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                            6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                            6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                            6'b011110, 6'b101011};
  logic [3:0] enc4 [8]  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [7:0] k_list [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                              8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [5:0] bad6 [6]  = '{6'b000000, 6'b111111, 6'b000011, 6'b111100, 6'b011111, 6'b100000};

  bit [8:0] dict [int];

  // reference state
  bit         m_rd;
  int         m_state;
  int         m_commas;
  int         m_errs;
  int         m_cnt;
  logic [7:0] m_sal;
  bit         m_k, m_val, m_ec, m_ed;

  function automatic logic [5:0] pick6(input logic [5:0] neg, input bit r);
    if (r && ($countones(neg) != 3 || neg == 6'b111000)) return ~neg;
    return neg;
  endfunction

  function automatic logic [3:0] pick4(input logic [3:0] neg, input bit r);
    if (r && ($countones(neg) != 2 || neg == 4'b1100)) return ~neg;
    return neg;
  endfunction

  function automatic logic [9:0] encode(input logic [7:0] b, input bit k, input bit r);
    logic [4:0] y;
    logic [2:0] x;
    logic [5:0] s;
    logic [3:0] f;
    logic [9:0] w;
    bit         r1;
    bit         alt;
    y = b[4:0];
    x = b[7:5];
    if (k && y == 5'd28) begin
      f = (x == 3'd7) ? 4'b1000 : pick4(enc4[x], 1'b1);
      w = {6'b001111, f};
      return r ? ~w : w;
    end
    s   = pick6(enc6[y], r);
    r1  = ($countones(s) == 3) ? r : ($countones(s) > 3);
    alt = (x == 3'd7) && (k || (!r1 && (y == 17 || y == 18 || y == 20)) ||
                          (r1 && (y == 11 || y == 13 || y == 14)));
    f   = alt ? (r1 ? 4'b1000 : 4'b0111) : pick4(enc4[x], r1);
    return {s, f};
  endfunction

  // Which RD a sub-block is meant for: +1 for RD-, -1 for RD+, 0 for either.
  function automatic int lean(input logic [5:0] v, input int n);
    int d;
    d = 2 * $countones(v) - n;
    if (d > 0) return 1;
    if (d < 0) return -1;
    if (n == 6 && v == 6'b111000) return 1;
    if (n == 6 && v == 6'b000111) return -1;
    if (n == 4 && v == 6'b001100) return 1;
    if (n == 4 && v == 6'b000011) return -1;
    return 0;
  endfunction

  function automatic bit rd_next(input logic [5:0] v, input int n, input bit r);
    int d;
    d = 2 * $countones(v) - n;
    if (d == 0) return r;
    return d > 0;
  endfunction

  task automatic model_reset();
    m_rd = 0; m_state = 0; m_commas = 0; m_errs = 0; m_cnt = 0;
    m_sal = 8'h00; m_k = 0; m_val = 0; m_ec = 0; m_ed = 0;
  endtask

  task automatic model_word(input bit e, input logic [9:0] code);
    logic [5:0] s;
    logic [5:0] f;
    bit         rm, viol, werr, cm;
    if (!e) begin
      m_val = 0; m_ec = 0; m_ed = 0;
      return;
    end
    m_val = 1;
    s = code[9:4];
    f = {2'b00, code[3:0]};
    if (!dict.exists(int'(code))) begin
      m_ec = 1; m_ed = 0; m_sal = 8'h00; m_k = 0;
    end else begin
      m_ec  = 0;
      viol  = (lean(s, 6) > 0 && m_rd) || (lean(s, 6) < 0 && !m_rd);
      rm    = rd_next(s, 6, m_rd);
      viol  = viol || (lean(f, 4) > 0 && rm) || (lean(f, 4) < 0 && !rm);
      m_rd  = rd_next(f, 4, rm);
      m_ed  = viol;
      m_sal = dict[int'(code)][7:0];
      m_k   = dict[int'(code)][8];
    end
    werr = m_ec || m_ed;
    cm   = !werr && m_k && m_sal[4:0] == 5'd28 &&
           (m_sal[7:5] == 3'd1 || m_sal[7:5] == 3'd5 || m_sal[7:5] == 3'd7);
    if (m_state == 0) begin
      if (cm) begin m_state = 1; m_commas = 1; end
    end else if (m_state == 1) begin
      if (werr) begin m_state = 0; m_commas = 0; end
      else if (cm) begin
        m_commas++;
        if (m_commas == 3) begin m_state = 2; m_errs = 0; end
      end
    end else begin
      if (werr) begin
        m_errs++;
        if (m_errs == 3) begin m_state = 0; m_errs = 0; m_commas = 0; end
      end else m_errs = 0;
    end
`ifdef DEC_CONT_ERR_EN
    if (werr && m_cnt < CONT_MAX) m_cnt++;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, steps, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("salidas", 32'(salidas), 32'(m_sal));
    chk("K", 32'(K), 32'(m_k));
    chk("valido", 32'(valido), 32'(m_val));
    chk("err_codigo", 32'(err_codigo), 32'(m_ec));
    chk("err_disp", 32'(err_disp), 32'(m_ed));
    chk("rd", 32'(rd), 32'(m_rd));
    chk("sincronizado", 32'(sincronizado), 32'(m_state == 2));
    chk("cont_err", 32'(cont_err), 32'(m_cnt));
  endtask

  task automatic show(input string what);
    $display("%s %0d enb=%0b rst=%0b in=%b | sal=%h K=%0b val=%0b ec=%0b ed=%0b rd=%0b sync=%0b cnt=%0d",
             what, steps, enb, rst, entradas, salidas, K, valido, err_codigo, err_disp, rd,
             sincronizado, cont_err);
  endtask

  task automatic step(input bit e, input logic [9:0] code);
    @(negedge clk);
    enb = e;
    entradas = code;
    @(posedge clk);
    #1;
    steps++;
    model_word(e, code);
    check_all();
    show("word");
  endtask

  task automatic do_reset(input logic [9:0] code);
    @(negedge clk);
    rst = 1'b1;
    enb = 1'b1;
    entradas = code;
    @(posedge clk);
    #1;
    steps++;
    model_reset();
    check_all();
    show("reset");
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    bit         k, use_rd, e;
    int         kind;
    logic [9:0] code;

    rst = 1'b1;
    enb = 1'b0;
    entradas = 10'd0;
    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v < 256; v++) dict[int'(encode(8'(v), 1'b0, r[0]))] = {1'b0, 8'(v)};
      for (int j = 0; j < 12; j++) dict[int'(encode(k_list[j], 1'b1, r[0]))] = {1'b1, k_list[j]};
    end
    model_reset();
    repeat (2) @(posedge clk);
    do_reset(10'b1001110100);

    // directed sequence
    step(1'b1, 10'b1001110100);
    step(1'b1, K28_5_NEG);
    step(1'b1, K28_5_POS);
    step(1'b1, K28_5_NEG);
    step(1'b1, K28_5_POS);
    step(1'b1, 10'b1010101010);
    step(1'b1, 10'b0110001011);
    step(1'b1, 10'b1010101010);
    repeat (3) step(1'b1, 10'b1111110000);
    step(1'b1, 10'b1001110000);
    for (int i = 0; i < 4; i++) step(1'b0, 10'(i * 173 + 5));
    repeat (3) step(1'b1, encode(8'hBC, 1'b1, m_rd));
    step(1'b1, encode(8'h3C, 1'b1, m_rd));
    step(1'b1, encode(8'hFE, 1'b1, m_rd));
    step(1'b1, encode(8'hF1, 1'b0, m_rd));
    do_reset(encode(8'h55, 1'b0, m_rd));
    step(1'b1, encode(8'hA5, 1'b0, 1'b0));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      e      = ($urandom_range(0, 9) != 0);
      kind   = $urandom_range(0, 99);
      use_rd = ($urandom_range(0, 9) == 0) ? !m_rd : m_rd;
      if (kind < 22) begin
        b = {($urandom_range(0, 2) == 0) ? 3'd1 : (($urandom_range(0, 1) == 0) ? 3'd5 : 3'd7), 5'd28};
        k = 1'b1;
        code = encode(b, k, use_rd);
      end else if (kind < 30) begin
        b = k_list[$urandom_range(0, 11)];
        code = encode(b, 1'b1, use_rd);
      end else if (kind < 37) begin
        code = {bad6[$urandom_range(0, 5)], 4'($urandom_range(0, 15))};
      end else begin
        b = 8'($urandom_range(0, 255));
        code = encode(b, 1'b0, use_rd);
      end
      if (i == 200) do_reset(code);
      else step(e, code);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
